// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: boot-loader writes until boot completes, then
// round-robin between CPU fetch and data ports with one outstanding read.
module ram_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RAM_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                boot_req,
    input  logic [ADDR_W-1:0]   boot_addr,
    input  logic [DATA_W-1:0]   boot_wdata,
    input  logic                boot_done,
    output logic                boot_gnt,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                ram_en,
    output logic                ram_we,
    output logic [DATA_W/8-1:0] ram_be,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_wdata,
    input  logic [DATA_W-1:0]   ram_rdata,
    output logic                we_stall,
    output logic                booting
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned LAT_W = 3;

    typedef enum logic [1:0] {BOOT, IDLE, RD_WAIT} state_t;
    typedef enum logic {SEL_IF = 1'b0, SEL_DM = 1'b1} sel_t;

    state_t            state_q, state_d;
    sel_t              rr_q, rr_d;
    sel_t              owner_q, owner_d;
    logic [LAT_W-1:0]  lat_q, lat_d;

    logic can_arb;
    logic pick_dm;
    logic pick_if;

    // The rvalid cycle of a read doubles as an arbitration slot.
    assign can_arb = (state_q == IDLE) || (state_q == RD_WAIT && lat_q == '0);
    assign pick_dm = can_arb && dm_req && (!if_req || rr_q == SEL_DM);
    assign pick_if = can_arb && if_req && !pick_dm;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            rr_q    <= SEL_DM;
            owner_q <= SEL_IF;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        lat_d   = lat_q;
        unique case (state_q)
            BOOT: begin
                if (boot_done && !boot_req) state_d = IDLE;
            end
            IDLE, RD_WAIT: begin
                if (state_q == RD_WAIT && lat_q != '0) begin
                    lat_d = lat_q - LAT_W'(1);
                end else if (pick_if || (pick_dm && !dm_we)) begin
                    state_d = RD_WAIT;
                    lat_d   = LAT_W'(RAM_LAT - 1);
                    owner_d = pick_dm ? SEL_DM : SEL_IF;
                end else begin
                    state_d = IDLE;
                end
                if (pick_dm)      rr_d = SEL_IF;
                else if (pick_if) rr_d = SEL_DM;
            end
            default: state_d = BOOT;
        endcase
    end

    // Output logic: grants and RAM strobe are combinational in the issue cycle
    always_comb begin
        boot_gnt  = 1'b0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = ram_rdata;
        dm_rdata  = ram_rdata;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        booting   = 1'b0;
        if (state_q == BOOT) begin
            booting  = 1'b1;
            boot_gnt = boot_req;
            if (boot_req) begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_be    = {BE_W{1'b1}};
                ram_addr  = boot_addr;
                ram_wdata = boot_wdata;
            end
        end else begin
            if (state_q == RD_WAIT && lat_q == '0) begin
                if_rvalid = (owner_q == SEL_IF);
                dm_rvalid = (owner_q == SEL_DM);
            end
            if (pick_if) begin
                if_gnt   = 1'b1;
                ram_en   = 1'b1;
                ram_be   = {BE_W{1'b1}};
                ram_addr = if_addr;
            end else if (pick_dm) begin
                dm_gnt    = 1'b1;
                ram_en    = 1'b1;
                ram_we    = dm_we;
                ram_be    = dm_we ? dm_be : {BE_W{1'b1}};
                ram_addr  = dm_addr;
                ram_wdata = dm_wdata;
            end
        end
        we_stall = (state_q == BOOT) || (if_req && !if_gnt) || (dm_req && !dm_gnt);
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Single-port RAM arbiter and sequencer between three requesters: the boot loader (write-only), CPU instruction fetch, and CPU data access.
- After reset it services only the boot loader until boot completes.
- It then round-robins between fetch and data, tracking one outstanding read at a time.
- It drives the CPU stall flag in the CPU/RAM flags interface.

Parameters:
- ADDR_W, 32, address width for all ports.
- DATA_W, 32, data width for all ports.
- RAM_LAT, 2, cycles from read grant to ram_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- boot_req  in  1  boot write request
- boot_addr  in  ADDR_W  boot write address
- boot_wdata  in  DATA_W  boot write data
- boot_done  in  1  level; boot image fully written
- boot_gnt  out  1  boot write accepted this cycle
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch data valid
- if_rdata  out  DATA_W  fetch data
- dm_req  in  1  data request
- dm_we  in  1  1 = write, 0 = read
- dm_be  in  DATA_W/8  byte enables (writes)
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  data write value
- dm_gnt  out  1  data request accepted this cycle
- dm_rvalid  out  1  data read valid
- dm_rdata  out  DATA_W  data read value
- ram_en  out  1  RAM access strobe
- ram_we  out  1  RAM write
- ram_be  out  DATA_W/8  RAM byte enables
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid RAM_LAT cycles after a read strobe
- we_stall  out  1  CPU stall flag
- booting  out  1  high while in BOOT

Behaviour:
- States: BOOT, IDLE, RD_WAIT. Reset state is BOOT.
- Registers: rr_ptr, owner (IF/DM), lat_cnt (3 bits).
- Reset values:
  - boot_gnt, if_gnt, dm_gnt, if_rvalid, dm_rvalid, ram_en, ram_we all 0; ram_be 0.
  - we_stall = 1, booting = 1.
  - rr_ptr = DM, so DM wins the first tie.
- Grant timing:
  - Grants are combinational in the cycle the access is issued.
  - gnt=1 implies ram_en=1 in the same cycle, with ram_addr/ram_we/ram_be/ram_wdata taken from the winner.
  - Requester must hold req and its payload until gnt; it may drop or change them the cycle after.
- BOOT state:
  - boot_req=1 -> boot_gnt=1, ram_we=1, ram_be all ones.
  - if_req and dm_req are never granted.
  - Transition to IDLE at the clock edge where boot_done=1 and boot_req=0.
  - A boot_req in the same cycle as boot_done is granted; the exit is deferred until boot_req drops.
- Boot port after BOOT: ignored until the next reset; boot_gnt stays 0.
- IDLE state:
  - Only one of if_req/dm_req asserted -> it wins.
  - Both asserted -> rr_ptr decides; after any IF/DM grant, rr_ptr points to the loser.
  - Fetch is always a read: ram_we=0, ram_be all ones.
  - DM write -> completes in the grant cycle; remains in IDLE, so back-to-back writes every cycle are allowed.
  - Any read grant -> load lat_cnt=RAM_LAT-1, latch owner, go to RD_WAIT. If RAM_LAT=1, rvalid is asserted the next cycle.
- RD_WAIT state:
  - No new grants while lat_cnt≠0; lat_cnt decrements each cycle.
  - Read granted at cycle T -> owner's rvalid=1 at cycle T+RAM_LAT for exactly one cycle.
  - owner's rdata = ram_rdata, combinational passthrough in the rvalid cycle.
  - In the rvalid cycle the arbiter behaves as IDLE (may grant a new request), giving read-to-read spacing of RAM_LAT cycles.
- Non-owner outputs: the non-owner rvalid is never asserted. if_rdata/dm_rdata are don't-care when their rvalid=0.
- we_stall:
  - 1 in BOOT.
  - Otherwise 1 when (if_req & ~if_gnt) | (dm_req & ~dm_gnt).
  - Combinational.
- Reset mid-read: an outstanding read is abandoned, no rvalid is ever issued for it, state returns to BOOT.

Test Plan:
- Reset, then three boot writes (addr 0x0/0x4/0x8, data 0x11/0x22/0x33) while if_req=1 -> three boot_gnt pulses, if_gnt=0 throughout, we_stall=1; boot_done=1 with boot_req=0 -> IDLE the next cycle, booting=0.
- After boot, a single if_req read at 0x4 with RAM_LAT=2 -> if_gnt at T, if_rvalid=1 at T+2 with if_rdata=0x22, no dm_rvalid.
- if_req and dm_req (read) held continuously -> grant order DM, IF, DM, IF… one grant every 2 cycles; we_stall high while either is ungranted.
- dm writes on 4 consecutive cycles (be=4'b0011) -> 4 dm_gnt in 4 cycles, ram_be=0011, no rvalid pulses.
- boot_req and boot_done asserted together -> write granted, state stays BOOT; next cycle boot_req=0 -> IDLE.
- Assert rst one cycle after a dm read grant -> no dm_rvalid afterward, all outputs at reset values, booting=1.
